clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 127 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider (/2, /4, /8, /16) with a run/stop control
// and a glitch-free ratio change that only takes effect at a period wrap.
//
// Ports:
//   clk      : single clock, all state changes on its rising edge
//   reset    : asynchronous, active-high
//   run      : level, 1 requests divided-clock generation
//   sel_req  : one-cycle pulse requesting a ratio change
//   sel_val  : requested ratio code, sampled only with sel_req
//   div_out  : divided clock, 50% duty, period 2^(cur_sel+1) cycles
//   tick     : pulse on the last cycle of each div_out period
//   sel_ack  : pulse in the cycle a requested ratio takes effect
//   busy     : high while a ratio change waits for the period wrap
//   cur_sel  : ratio code in effect
//   active   : high while generating (RUN or PEND)
module clk_div_ctrl #(
  parameter logic [1:0] RESET_SEL = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       sel_req,
  input  logic [1:0] sel_val,
  output logic       div_out,
  output logic       tick,
  output logic       sel_ack,
  output logic       busy,
  output logic [1:0] cur_sel,
  output logic       active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cur_sel_q, cur_sel_d;
  logic [1:0] pend_sel_q, pend_sel_d;
  logic       sel_ack_q, sel_ack_d;

  // Terminal count (P-1) and half period (P/2) for the ratio in effect.
  logic [3:0] last_cnt;
  logic [3:0] half_cnt;
  logic       wrap;

  always_comb begin
    last_cnt = 4'd1;
    unique case (cur_sel_q)
      2'd0: last_cnt = 4'd1;
      2'd1: last_cnt = 4'd3;
      2'd2: last_cnt = 4'd7;
      2'd3: last_cnt = 4'd15;
    endcase
  end

  assign half_cnt = 4'd1 << cur_sel_q;
  assign wrap     = (cnt_q == last_cnt);

  // Outputs come from registered state only.
  assign active  = (state_q != IDLE);
  assign busy    = (state_q == PEND);
  assign div_out = active && (cnt_q >= half_cnt);
  assign tick    = active && wrap;
  assign sel_ack = sel_ack_q;
  assign cur_sel = cur_sel_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    sel_ack_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        // No period in flight, so a new ratio applies at once.
        if (sel_req) begin
          cur_sel_d = sel_val;
          sel_ack_d = 1'b1;
        end
        if (run) state_d = RUN;
      end
      RUN: begin
        cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
        // A request, even on the wrap cycle, waits for the next wrap.
        if (sel_req) begin
          pend_sel_d = sel_val;
          state_d    = PEND;
        end else if (wrap && !run) begin
          state_d = IDLE;
        end
      end
      PEND: begin
        cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
        if (wrap) begin
          cur_sel_d = pend_sel_q;
          sel_ack_d = 1'b1;
          state_d   = run ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      cur_sel_q  <= RESET_SEL;
      pend_sel_q <= 2'd0;
      sel_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      sel_ack_q  <= sel_ack_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl.
// Output vector: {div_out,tick,sel_ack,busy,active,cur_sel}.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       sel_req;
  logic [1:0] sel_val;
  logic       div_out;
  logic       tick;
  logic       sel_ack;
  logic       busy;
  logic [1:0] cur_sel;
  logic       active;

  int checks = 0;
  int failures = 0;

  clk_div_ctrl #(.RESET_SEL(2'd1)) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .sel_req (sel_req),
    .sel_val (sel_val),
    .div_out (div_out),
    .tick    (tick),
    .sel_ack (sel_ack),
    .busy    (busy),
    .cur_sel (cur_sel),
    .active  (active)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {div_out, tick, sel_ack, busy, active, cur_sel};

  task automatic chk(input string tag, input logic [6:0] got,
                     input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic sr,
                      input logic [1:0] sv, input logic [6:0] exp);
    run     = r;
    sel_req = sr;
    sel_val = sv;
    @(posedge clk);
    #1;
    chk(tag, outs, exp);
  endtask

  initial begin
    run = 1'b0;
    sel_req = 1'b0;
    sel_val = 2'd0;
    reset = 1'b1;
    #1;
    chk("reset", outs, 7'b0000001);
    @(posedge clk);
    #1;
    chk("reset_hold", outs, 7'b0000001);
    reset = 1'b0;

    // Idle stays idle; ratio change in IDLE acks next cycle.
    step("idle", 0, 0, 0, 7'b0000001);
    step("idle_sel0", 0, 1, 0, 7'b0010000);
    // /2 running.
    step("div2_c0", 1, 0, 0, 7'b0000100);
    for (int i = 0; i < 3; i++) begin
      step("div2_c1", 1, 0, 0, 7'b1100100);
      step("div2_c0b", 1, 0, 0, 7'b0000100);
    end
    step("div2_c1e", 1, 0, 0, 7'b1100100);
    step("div2_stop", 0, 0, 0, 7'b0000000);

    // /16 set in IDLE then run.
    step("idle_sel3", 0, 1, 3, 7'b0010011);
    step("div16_c0", 1, 0, 0, 7'b0000111);
    for (int i = 1; i < 16; i++)
      step("div16_a", 1, 0, 0,
           {i >= 8, i == 15, 3'b001, 2'd3});
    step("div16_c0b", 1, 0, 0, 7'b0000111);
    // run dropped early: period still completes.
    for (int i = 1; i < 16; i++)
      step("div16_stop", 0, 0, 0,
           {i >= 8, i == 15, 3'b001, 2'd3});
    step("div16_idle", 0, 0, 0, 7'b0000011);

    // /4, same-ratio request at cnt=1.
    step("idle_sel1", 0, 1, 1, 7'b0010001);
    step("div4_c0", 1, 0, 0, 7'b0000101);
    step("div4_c1", 1, 0, 0, 7'b0000101);
    step("same_pend2", 1, 1, 1, 7'b1001101);
    step("same_pend3", 1, 0, 0, 7'b1101101);
    step("same_ack", 1, 0, 0, 7'b0010101);
    step("same_c1", 1, 0, 0, 7'b0000101);
    step("same_c2", 1, 0, 0, 7'b1000101);
    step("same_c3", 1, 0, 0, 7'b1100101);
    step("same_c0", 1, 0, 0, 7'b0000101);

    // Request /8 at cnt=0, second request at cnt=2 ignored.
    step("dbl_pend1", 1, 1, 2, 7'b0001101);
    step("dbl_pend2", 1, 0, 0, 7'b1001101);
    step("dbl_pend3", 1, 1, 3, 7'b1101101);
    step("dbl_ack", 1, 0, 0, 7'b0010110);
    step("dbl_c1", 1, 0, 0, 7'b0000110);

    // /8, run dropped at cnt=2.
    step("div8_c2", 1, 0, 0, 7'b0000110);
    step("div8_c3", 0, 0, 0, 7'b0000110);
    for (int i = 4; i < 7; i++)
      step("div8_hi", 0, 0, 0, 7'b1000110);
    step("div8_c7", 0, 0, 0, 7'b1100110);
    step("div8_idle", 0, 0, 0, 7'b0000010);
    step("div8_idle2", 0, 0, 0, 7'b0000010);

    // /16 in PEND, async reset at cnt=5.
    step("r_sel3", 0, 1, 3, 7'b0010011);
    step("r_c0", 1, 0, 0, 7'b0000111);
    step("r_c1", 1, 0, 0, 7'b0000111);
    step("r_pend2", 1, 1, 2, 7'b0001111);
    for (int i = 3; i < 6; i++)
      step("r_pend", 1, 0, 0, 7'b0001111);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst", outs, 7'b0000001);
    @(posedge clk);
    #1;
    chk("async_hold", outs, 7'b0000001);
    reset = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 3; i++)
      step("post_rst", 0, 0, 0, 7'b0000001);

    // IDLE: request and run together -> new ratio from first period.
    step("both_c0", 1, 1, 0, 7'b0010100);
    step("both_c1", 1, 0, 0, 7'b1100100);
    // Request on the wrap cycle defers to next wrap.
    step("wrap_pend0", 1, 1, 1, 7'b0001100);
    step("wrap_pend1", 1, 0, 0, 7'b1101100);
    step("wrap_ack", 1, 0, 0, 7'b0010101);
    step("wrap_c1", 1, 0, 0, 7'b0000101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
